// File: rtl/ninjakun_pkg.sv
// Shared types and constants for the NinjaKun interrupt controller.
package ninjakun_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_ACK,
        ST_SERVICE
    } state_t;

    localparam int unsigned SRC_VBLK     = 0;
    localparam int unsigned SRC_TIMER    = 1;
    localparam int unsigned SRC_SNDLATCH = 2;
    localparam int unsigned SRC_SPARE    = 3;

    localparam logic [7:0] VBASE_DEFAULT = 8'hE0;

    // Mode-2 vector: base + 2*index, wrapping at 8 bits.
    function automatic logic [7:0] vec_of(input logic [7:0] base, input int unsigned idx);
        return base + 8'(idx * 2);
    endfunction

endpackage

// File: rtl/ninjakun_prienc.sv
// Lowest-index-wins priority encoder; o_valid is low when no request bit is set.
module ninjakun_prienc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && !o_valid) begin
                o_valid = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ninjakun_intctl.sv
// Prioritised, maskable Z80 mode-2 interrupt controller.
// Define NINJAKUN_INTCTL_NEST_EN to allow higher-priority sources to nest during service.
module ninjakun_intctl
    import ninjakun_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter logic [7:0]  VBASE = VBASE_DEFAULT
) (
    input  logic            MCLK,
    input  logic            RESET,
    input  logic [NSRC-1:0] SRC_REQ,
    input  logic            MASK_WE,
    input  logic [NSRC-1:0] MASK_DI,
    input  logic            CPU_IACK,
    input  logic            CPU_EOI,
    output logic            INT,
    output logic            VEC_OE,
    output logic [7:0]      VEC_DO,
    output logic [NSRC-1:0] ACK_SRC,
    output logic [NSRC-1:0] IN_SERVICE
);

    localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    state_t            r_state, w_next;
    logic [NSRC-1:0]   r_prev, r_pend, r_mask, r_isr, r_ack_src;
    logic              r_iack_d, r_int, r_vec_oe;
    logic [7:0]        r_vec_do;

    logic [NSRC-1:0]   w_rise, w_req, w_cand_oh, w_isr_oh, w_isr_eoi;
    logic              w_cand_valid, w_isr_valid, w_cand_ok, w_iack_rise;
    logic              w_take, w_spur;
    logic [IW-1:0]     w_cand_idx, w_isr_idx;

    assign w_rise      = SRC_REQ & ~r_prev;
    assign w_req       = r_pend & r_mask;
    assign w_iack_rise = CPU_IACK & ~r_iack_d;

    ninjakun_prienc #(.N(NSRC), .IW(IW)) u_cand (
        .i_req   (w_req),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    ninjakun_prienc #(.N(NSRC), .IW(IW)) u_isr (
        .i_req   (r_isr),
        .o_valid (w_isr_valid),
        .o_idx   (w_isr_idx)
    );

    assign w_cand_oh = NSRC'(1) << w_cand_idx;
    assign w_isr_oh  = NSRC'(1) << w_isr_idx;
    assign w_isr_eoi = r_isr & ~w_isr_oh;

`ifdef NINJAKUN_INTCTL_NEST_EN
    assign w_cand_ok = w_cand_valid && (!w_isr_valid || (w_cand_idx < w_isr_idx));
`else
    assign w_cand_ok = w_cand_valid && !w_isr_valid;
`endif

    // A candidate that vanishes in ASSERT falls back to SERVICE if a handler is still open.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_spur = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_spur = w_iack_rise;
                if (w_cand_ok) w_next = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (w_iack_rise && w_cand_ok) begin
                    w_take = 1'b1;
                    w_next = ST_ACK;
                end else begin
                    w_spur = w_iack_rise;
                    if (!w_cand_ok) w_next = w_isr_valid ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!CPU_IACK) w_next = ST_SERVICE;
            end
            ST_SERVICE: begin
                w_spur = w_iack_rise;
                if (CPU_EOI && (w_isr_eoi == '0)) w_next = ST_IDLE;
                else if (w_cand_ok)                w_next = ST_ASSERT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_prev    <= '0;
            r_pend    <= '0;
            r_mask    <= '1;
            r_isr     <= '0;
            r_ack_src <= '0;
            r_iack_d  <= 1'b0;
            r_int     <= 1'b0;
            r_vec_oe  <= 1'b0;
            r_vec_do  <= VBASE;
        end else begin
            r_state   <= w_next;
            r_prev    <= SRC_REQ;
            r_iack_d  <= CPU_IACK;
            // A fresh edge on the source being acknowledged keeps it pending.
            r_pend    <= (r_pend & ~(w_take ? w_cand_oh : '0)) | w_rise;
            r_int     <= (w_next == ST_ASSERT);
            r_ack_src <= w_take ? w_cand_oh : '0;
            if (MASK_WE) r_mask <= MASK_DI;
            if (w_take)
                r_isr <= r_isr | w_cand_oh;
            else if (r_state == ST_SERVICE && CPU_EOI)
                r_isr <= w_isr_eoi;
            if (w_iack_rise)    r_vec_oe <= 1'b1;
            else if (!CPU_IACK) r_vec_oe <= 1'b0;
            if (w_take)         r_vec_do <= vec_of(VBASE, 32'(w_cand_idx));
            else if (w_spur)    r_vec_do <= vec_of(VBASE, NSRC);
        end
    end

    assign INT        = r_int;
    assign VEC_OE     = r_vec_oe;
    assign VEC_DO     = r_vec_do;
    assign ACK_SRC    = r_ack_src;
    assign IN_SERVICE = r_isr;

endmodule

// File: tb/tb_ninjakun_intctl.sv
// Directed plus randomized bench for ninjakun_intctl; honours NINJAKUN_INTCTL_NEST_EN.
`timescale 1ns/1ps
module tb_ninjakun_intctl;
    import ninjakun_pkg::*;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] SRC_REQ = '0;
    logic       MASK_WE = 1'b0;
    logic [3:0] MASK_DI = '0;
    logic       CPU_IACK = 1'b0;
    logic       CPU_EOI = 1'b0;
    logic       INT, VEC_OE;
    logic [7:0] VEC_DO;
    logic [3:0] ACK_SRC, IN_SERVICE;

    int n_tests = 0;
    int n_fail  = 0;
    int model_pend = 0;
    int model_mask = 15;

    ninjakun_intctl #(.NSRC(4), .VBASE(8'hE0)) dut (
        .MCLK(MCLK), .RESET(RESET), .SRC_REQ(SRC_REQ), .MASK_WE(MASK_WE),
        .MASK_DI(MASK_DI), .CPU_IACK(CPU_IACK), .CPU_EOI(CPU_EOI), .INT(INT),
        .VEC_OE(VEC_OE), .VEC_DO(VEC_DO), .ACK_SRC(ACK_SRC), .IN_SERVICE(IN_SERVICE)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_int"},  32'(INT), 32'd0);
        chk({tag, "_oe"},   32'(VEC_OE), 32'd0);
        chk({tag, "_vec"},  32'(VEC_DO), 32'hE0);
        chk({tag, "_ack"},  32'(ACK_SRC), 32'd0);
        chk({tag, "_isr"},  32'(IN_SERVICE), 32'd0);
    endtask

    task automatic wait_int(input int budget, input string tag);
        int k = 0;
        while (INT !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(INT), 32'd1);
    endtask

    task automatic write_mask(input logic [3:0] m);
        MASK_DI = m;
        MASK_WE = 1'b1;
        tick();
        MASK_WE = 1'b0;
        model_mask = int'(m);
    endtask

    task automatic eoi();
        CPU_EOI = 1'b1;
        tick();
        CPU_EOI = 1'b0;
    endtask

    // Full ack (IACK held one extra cycle) returning the vector and source seen on entry.
    task automatic ack(output logic [7:0] vec, output logic [3:0] src);
        CPU_IACK = 1'b1;
        tick();
        vec = VEC_DO;
        src = ACK_SRC;
        tick();
        CPU_IACK = 1'b0;
        tick();
    endtask

    // Serve every enabled pending source in ascending-index order, randomizing the handshake.
    task automatic service_all(input string tag);
        int idx, hold, dly, lowmask;
        logic [7:0] ev, v0;
        logic [3:0] m2;
        while ((model_pend & model_mask) != 0) begin
            idx = -1;
            for (int b = 3; b >= 0; b--)
                if ((((model_pend & model_mask) >> b) & 1) == 1) idx = b;
            ev = 8'(8'hE0 + 2 * idx);
            wait_int(8, {tag, "_int"});
            CPU_IACK = 1'b1;
            tick();
            chk({tag, "_vec"}, 32'(VEC_DO), 32'(ev));
            chk({tag, "_acksrc"}, 32'(ACK_SRC), 32'(1 << idx));
            chk({tag, "_isr"}, 32'(IN_SERVICE), 32'(1 << idx));
            chk({tag, "_intlow"}, 32'(INT), 32'd0);
            model_pend &= ~(1 << idx);
            v0 = ev;
            if ($urandom_range(0, 1) == 1) begin
                lowmask = (2 << idx) - 1;
                m2 = 4'($urandom_range(0, 15) & (model_mask | ~lowmask));
                write_mask(m2);
            end else begin
                tick();
            end
            hold = $urandom_range(0, 2);
            repeat (hold) tick();
            chk({tag, "_vecstable"}, 32'(VEC_DO), 32'(v0));
            chk({tag, "_pulse"}, 32'(ACK_SRC), 32'd0);
            chk({tag, "_oe"}, 32'(VEC_OE), 32'd1);
            CPU_IACK = 1'b0;
            tick();
            chk({tag, "_oeoff"}, 32'(VEC_OE), 32'd0);
            dly = $urandom_range(0, 3);
            repeat (dly) tick();
            eoi();
            chk({tag, "_eoi"}, 32'(IN_SERVICE), 32'd0);
        end
        repeat (4) tick();
        chk({tag, "_quiet"}, 32'(INT), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [3:0] a, r;

        repeat (2) tick();
        chk_reset("reset");
        RESET = 1'b0;
        tick();

        // Single request on the timer source.
        SRC_REQ[SRC_TIMER] = 1'b1;
        tick();
        chk("single_int_n", 32'(INT), 32'd0);
        tick();
        chk("single_int_n2", 32'(INT), 32'd1);
        repeat (2) tick();
        CPU_IACK = 1'b1;
        tick();
        chk("single_vec", 32'(VEC_DO), 32'hE2);
        chk("single_oe", 32'(VEC_OE), 32'd1);
        chk("single_ack", 32'(ACK_SRC), 32'b0010);
        chk("single_intlow", 32'(INT), 32'd0);
        tick();
        chk("single_ackpulse", 32'(ACK_SRC), 32'd0);
        CPU_IACK = 1'b0;
        tick();
        chk("single_oeoff", 32'(VEC_OE), 32'd0);
        chk("single_isr", 32'(IN_SERVICE), 32'b0010);
        eoi();
        chk("single_eoi", 32'(IN_SERVICE), 32'd0);

        // EOI while nothing is in service is ignored.
        eoi();
        chk("idle_eoi_isr", 32'(IN_SERVICE), 32'd0);
        chk("idle_eoi_int", 32'(INT), 32'd0);

        // Simultaneous requests: lower index first.
        SRC_REQ = '0;
        tick();
        SRC_REQ = 4'b0101;
        tick();
        tick();
        chk("prio_int", 32'(INT), 32'd1);
        ack(v, a);
        chk("prio_vec1", 32'(v), 32'hE0);
        chk("prio_ack1", 32'(a), 32'b0001);
        eoi();
        chk("prio_idle", 32'(INT), 32'd0);
        tick();
        chk("prio_int2", 32'(INT), 32'd1);
        ack(v, a);
        chk("prio_vec2", 32'(v), 32'hE4);
        eoi();

        // Masked source still latches and fires once enabled.
        SRC_REQ = '0;
        write_mask(4'b1110);
        SRC_REQ[SRC_VBLK] = 1'b1;
        repeat (4) tick();
        chk("mask_noint", 32'(INT), 32'd0);
        write_mask(4'b1111);
        chk("mask_int_w1", 32'(INT), 32'd0);
        tick();
        chk("mask_int_w2", 32'(INT), 32'd1);
        ack(v, a);
        chk("mask_vec", 32'(v), 32'hE0);
        eoi();

        // Spurious acknowledge in IDLE.
        CPU_IACK = 1'b1;
        tick();
        chk("spur_vec", 32'(VEC_DO), 32'hE8);
        chk("spur_oe", 32'(VEC_OE), 32'd1);
        chk("spur_ack", 32'(ACK_SRC), 32'd0);
        tick();
        chk("spur_int", 32'(INT), 32'd0);
        CPU_IACK = 1'b0;
        tick();
        chk("spur_oeoff", 32'(VEC_OE), 32'd0);
        chk("spur_isr", 32'(IN_SERVICE), 32'd0);

        // New edge on the source being acknowledged keeps it pending.
        SRC_REQ = '0;
        tick();
        SRC_REQ[SRC_TIMER] = 1'b1;
        repeat (2) tick();
        chk("setwin_int", 32'(INT), 32'd1);
        SRC_REQ = '0;
        tick();
        SRC_REQ[SRC_TIMER] = 1'b1;
        CPU_IACK = 1'b1;
        tick();
        chk("setwin_vec", 32'(VEC_DO), 32'hE2);
        CPU_IACK = 1'b0;
        repeat (2) tick();
        eoi();
        tick();
        chk("setwin_reint", 32'(INT), 32'd1);
        ack(v, a);
        chk("setwin_vec2", 32'(v), 32'hE2);
        eoi();

        // Higher-priority request while sound-latch handler runs.
        SRC_REQ = '0;
        tick();
        SRC_REQ[SRC_SNDLATCH] = 1'b1;
        repeat (2) tick();
        ack(v, a);
        chk("nest_vec_outer", 32'(v), 32'hE4);
        chk("nest_isr_outer", 32'(IN_SERVICE), 32'b0100);
        SRC_REQ[SRC_VBLK] = 1'b1;
        repeat (2) tick();
`ifdef NINJAKUN_INTCTL_NEST_EN
        chk("nest_int", 32'(INT), 32'd1);
        ack(v, a);
        chk("nest_vec_inner", 32'(v), 32'hE0);
        chk("nest_isr_both", 32'(IN_SERVICE), 32'b0101);
        eoi();
        chk("nest_eoi1", 32'(IN_SERVICE), 32'b0100);
        eoi();
        chk("nest_eoi2", 32'(IN_SERVICE), 32'd0);
`else
        repeat (3) tick();
        chk("nest_noint", 32'(INT), 32'd0);
        eoi();
        chk("nest_eoi", 32'(IN_SERVICE), 32'd0);
        chk("nest_e1", 32'(INT), 32'd0);
        tick();
        chk("nest_e2", 32'(INT), 32'd1);
        ack(v, a);
        chk("nest_vec_inner", 32'(v), 32'hE0);
        eoi();
`endif

        // Reset while the vector is on the bus.
        SRC_REQ = '0;
        tick();
        SRC_REQ[SRC_SPARE] = 1'b1;
        repeat (2) tick();
        CPU_IACK = 1'b1;
        tick();
        chk("rstack_oe", 32'(VEC_OE), 32'd1);
        chk("rstack_vec", 32'(VEC_DO), 32'hE6);
        RESET = 1'b1;
        tick();
        chk_reset("rstack");
        RESET = 1'b0;
        CPU_IACK = 1'b0;
        SRC_REQ = '0;
        tick();
        chk("rstack_after_oe", 32'(VEC_OE), 32'd0);
        repeat (3) tick();
        chk("rstack_dropped", 32'(INT), 32'd0);

        // Randomized bursts checked against a pending/mask set model.
        model_pend = 0;
        model_mask = 15;
        for (int t = 0; t < 20; t++) begin
            SRC_REQ = '0;
            tick();
            write_mask(4'($urandom_range(0, 15)));
            r = 4'($urandom_range(1, 15));
            SRC_REQ = r;
            model_pend |= int'(r);
            tick();
            service_all("rand_a");
            write_mask(4'hF);
            service_all("rand_b");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ninjakun_intctl.md
# ninjakun_intctl

Prioritised, maskable Z80 interrupt controller for one NinjaKun CPU. Edge-detects up to NSRC level-style request lines (VBLANK tick, 240 Hz timer, sound latch, spare), latches them as pending, and drives a single INT line. It answers the CPU's interrupt-acknowledge cycle with a mode-2 vector and signals which source was taken. It sits between the IRQ-source logic and the CPU core, replacing direct IRQ/ACK wiring.

## Interface
Parameters:
- NSRC, 4, number of request sources (1..8); index 0 is highest priority
- VBASE, 8'hE0, mode-2 vector base; vector = VBASE + 2*index, 8-bit wrap

Ports:
- MCLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- SRC_REQ  in  NSRC  request lines; a 0->1 transition (sampled on MCLK) is one request
- MASK_WE  in  1  one-cycle strobe, loads MASK_DI into enable register
- MASK_DI  in  NSRC  enable bits (1 = enabled)
- CPU_IACK  in  1  high while CPU is in interrupt acknowledge (M1 & IORQ), qualified by the CPU wrapper
- CPU_EOI  in  1  one-cycle pulse on RETI decode
- INT  out  1  interrupt request to CPU, active-high
- VEC_OE  out  1  high while VEC_DO must be driven onto the data bus
- VEC_DO  out  8  vector byte
- ACK_SRC  out  NSRC  one-hot, one-cycle pulse naming the source taken
- IN_SERVICE  out  NSRC  in-service bitmask (debug/status)

## Operation
- Edge detect: per-source previous-sample register; rise sets PEND[i] the following cycle. Masked sources still latch PEND.
- Candidate = lowest index with PEND & MASK. Priority encoder is combinational on registered PEND/MASK.
- FSM states: IDLE, ASSERT, ACK, SERVICE.
  - IDLE: candidate exists -> ASSERT.
  - ASSERT: INT=1. Candidate disappears (mask write) -> IDLE, INT drops. CPU_IACK rise -> ACK.
  - ACK: winner index frozen on entry; PEND[win] cleared, ISR[win] set, ACK_SRC pulsed, all on the entry cycle; VEC_OE=1, VEC_DO stable while CPU_IACK high; INT=0. CPU_IACK fall -> SERVICE.
  - SERVICE: CPU_EOI clears lowest-index set ISR bit; ISR becomes zero -> IDLE.
- Spurious acknowledge (CPU_IACK rise in IDLE or SERVICE): VEC_DO = VBASE + 2*NSRC, VEC_OE high for the ack, no ACK_SRC, no PEND/ISR change, state unchanged.
- Same-cycle new edge on source being cleared by ACK: set wins, PEND stays 1.
- CPU_EOI with ISR zero: ignored.
- MASK_WE during ACK does not change the frozen winner.

## Timing
- Reset values: INT=0, VEC_OE=0, VEC_DO=VBASE, ACK_SRC=0, IN_SERVICE=0, PEND=0, MASK=all ones, edge registers=0, state IDLE.
- SRC_REQ rise at cycle n -> PEND at n+1 -> ASSERT at n+2 -> INT high at n+2 (registered output).
- CPU_IACK rise at cycle m (state ASSERT) -> VEC_OE, VEC_DO, ACK_SRC valid and INT low at m+1.
- CPU_IACK fall at k -> VEC_OE low at k+1.
- EOI at e clearing last ISR bit -> IDLE at e+1; a waiting candidate gives INT at e+2.
- RESET mid-operation: all state returns to reset values next edge; requests in flight are dropped.

## Configuration
- NINJAKUN_INTCTL_NEST_EN defined: in SERVICE, an enabled pending source with index lower than the lowest set ISR bit moves the FSM to ASSERT (nested interrupt); ISR holds multiple bits; each EOI clears the lowest set bit; IDLE reached when ISR empty.
- Undefined: no INT while any ISR bit is set; ISR is at most one-hot.

## Structure
- Shared package ninjakun_pkg: FSM state enum, source index constants (SRC_VBLK=0, SRC_TIMER=1, SRC_SNDLATCH=2, SRC_SPARE=3), default VBASE.
- One sub-module: ninjakun_prienc (NSRC-wide lowest-index priority encoder, outputs valid + index); used for candidate selection and EOI ISR clearing.

## Test plan
- Single request: SRC_REQ[1] rises, IACK 3 cycles later -> INT high 2 cycles after edge, VEC_DO=8'hE2, ACK_SRC=4'b0010 for 1 cycle, IN_SERVICE=4'b0010 until EOI.
- Priority: SRC_REQ[2] and [0] rise together -> first ack vector 8'hE0; after EOI, second ack vector 8'hE4.
- Masking: MASK=4'b1110, SRC_REQ[0] rises -> no INT; write MASK=4'b1111 -> INT within 2 cycles, vector 8'hE0.
- Spurious: IACK in IDLE -> VEC_DO=8'hE8, VEC_OE high, ACK_SRC=0, state stays IDLE.
- Nesting (macro on/off): in service of src 2, src 0 rises -> with NINJAKUN_INTCTL_NEST_EN INT reasserts and IN_SERVICE=4'b0101; without, INT stays low until EOI.
- Reset during ACK: RESET pulse while VEC_OE high -> all outputs at reset values next cycle.
